// File: rtl/psum_drain_if.sv
// Bundle of all non-clock signals of the psum drain unit.
//   ctrl side : drain_en, psum_len, done_psum -> unit; wr_psum_in, co_psum <- unit
//   spad side : psum_ren, psum_raddr <- unit; psum_rdata -> unit (1-cycle read latency)
//   stream    : out_valid, out_data, out_last <- unit; out_ready -> unit
//   status    : busy <- unit
// master = the drain unit, slave = its environment.
interface psum_drain_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
) ();
  logic              drain_en;
  logic [ADDR_W:0]   psum_len;
  logic              done_psum;
  logic              wr_psum_in;
  logic              co_psum;
  logic              psum_ren;
  logic [ADDR_W-1:0] psum_raddr;
  logic [DATA_W-1:0] psum_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;
  logic              busy;

  modport master (
    input  drain_en, psum_len, done_psum, psum_rdata, out_ready,
    output wr_psum_in, co_psum, psum_ren, psum_raddr, out_valid, out_data, out_last, busy
  );

  modport slave (
    output drain_en, psum_len, done_psum, psum_rdata, out_ready,
    input  wr_psum_in, co_psum, psum_ren, psum_raddr, out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/psum_drain_unit.sv
// Drains a batch of partial sums from the psum scratchpad to a valid/ready stream.
// Requests the controller's write phase (wr_psum_in), issues one scratchpad read per
// done_psum strobe while credit allows, flags the final read with co_psum, and buffers
// returned words in a 2-entry FIFO with a bypass path so an empty FIFO adds no latency.
// Ports: clk, rst (synchronous, active high), bus (psum_drain_if.master).
module psum_drain_unit #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16
) (
  input logic          clk,
  input logic          rst,
  psum_drain_if.master bus
);
  localparam logic [ADDR_W:0] DepthLen = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] OneLen   = (ADDR_W + 1)'(1);

  typedef enum logic [1:0] {StIdle, StReq, StStream, StFlush} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              inflight_q;
  logic              last_tag_q;
  logic [DATA_W-1:0] fifo_data_q [2];
  logic              fifo_last_q [2];
  logic              wr_ptr_q, rd_ptr_q;
  logic [1:0]        fifo_cnt_q, fifo_cnt_d;

  logic              in_rd, issue, co;
  logic              fifo_empty, pop, fifo_pop, push;
  logic [DATA_W-1:0] head_data;
  logic              head_last;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Stream side: the word returning this cycle is shown directly when the FIFO is empty.
  always_comb begin
    fifo_empty    = (fifo_cnt_q == 2'd0);
    bus.out_valid = !fifo_empty || inflight_q;
    head_data     = fifo_empty ? bus.psum_rdata : fifo_data_q[rd_ptr_q];
    head_last     = fifo_empty ? last_tag_q : fifo_last_q[rd_ptr_q];
    bus.out_data  = bus.out_valid ? head_data : '0;
    bus.out_last  = bus.out_valid && head_last;
    pop           = bus.out_valid && bus.out_ready;
    fifo_pop      = pop && !fifo_empty;
    // A returning word consumed through the bypass is never stored.
    push          = inflight_q && !(fifo_empty && pop);
    fifo_cnt_d    = fifo_cnt_q + {1'b0, push} - {1'b0, fifo_pop};
  end

  // FSM outputs
  always_comb begin
    in_rd          = (state_q == StReq) || (state_q == StStream);
    // Stored words plus the one in flight may not exceed the two FIFO slots.
    issue          = in_rd && bus.done_psum &&
                     (({1'b0, fifo_cnt_q} + {2'b0, inflight_q}) < 3'd2);
    co             = issue && (rd_cnt_q == len_q - OneLen);
    bus.wr_psum_in = in_rd;
    bus.busy       = (state_q != StIdle);
    bus.psum_ren   = issue;
    bus.co_psum    = co;
    bus.psum_raddr = rd_cnt_q[ADDR_W-1:0];
  end

  // Next state
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    rd_cnt_d = issue ? rd_cnt_q + OneLen : rd_cnt_q;
    case (state_q)
      StIdle: begin
        if (bus.drain_en && (bus.psum_len != '0)) begin
          state_d  = StReq;
          len_d    = (bus.psum_len > DepthLen) ? DepthLen : bus.psum_len;
          rd_cnt_d = '0;
        end
      end
      StReq:    if (issue) state_d = co ? StFlush : StStream;
      StStream: if (co) state_d = StFlush;
      // No reads issue here, so an empty FIFO next cycle means nothing is left.
      StFlush:  if (fifo_cnt_d == 2'd0) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q   <= '0;
      len_q      <= '0;
      inflight_q <= 1'b0;
      last_tag_q <= 1'b0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      fifo_cnt_q <= 2'd0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      len_q      <= len_d;
      inflight_q <= issue;
      last_tag_q <= co;
      fifo_cnt_q <= fifo_cnt_d;
      if (push)     wr_ptr_q <= ~wr_ptr_q;
      if (fifo_pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // FIFO storage; contents are don't-care while the count is zero.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_q[wr_ptr_q] <= bus.psum_rdata;
      fifo_last_q[wr_ptr_q] <= last_tag_q;
    end
  end
endmodule

// File: tb/tb_psum_drain_unit.sv
module tb_psum_drain_unit;
  localparam int DW = 16;
  localparam int AW = 4;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psum_drain_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  psum_drain_unit #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  // Scratchpad model: registered read, junk when not reading.
  logic [DW-1:0] mem [DEPTH];
  always @(posedge clk) bus.psum_rdata <= bus.psum_ren ? mem[bus.psum_raddr] : DW'($urandom);

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference model: a batch is a list of words; words read but not yet accepted
  // downstream sit in 'avail' (at most 2), and a read's word is visible next cycle.
  typedef struct { logic [DW-1:0] d; bit last; } beat_t;
  beat_t avail[$];
  bit active = 0;
  int len = 0, issued = 0;
  bit model_ok = 0;
  bit s_rst = 0, s_pop = 0, s_ren = 0, s_drain = 0;
  int s_len = 0;

  // Observation logs for hand-computed checks
  typedef struct { int cyc; int addr; bit co; } ren_t;
  typedef struct { int cyc; logic [DW-1:0] d; bit last; } blog_t;
  ren_t  ren_log[$];
  blog_t beat_log[$];
  bit wr_hist[int];
  bit busy_hist[int];
  int cyc = 0;

  always @(negedge clk) begin
    bit was, e_wr, e_ren, e_valid;
    // Apply what happened at the posedge just past.
    if (s_rst) begin
      active = 0; len = 0; issued = 0; avail.delete(); model_ok = 1;
    end else if (model_ok) begin
      was = active;
      if (s_pop) void'(avail.pop_front());
      if (s_ren) begin
        avail.push_back('{d: mem[issued[AW-1:0]], last: (issued == len - 1)});
        issued++;
      end
      if (was && issued == len && avail.size() == 0) active = 0;
      else if (!was && s_drain && s_len != 0) begin
        active = 1; len = (s_len > DEPTH) ? DEPTH : s_len; issued = 0;
      end
    end
    e_wr    = active && issued < len;
    e_ren   = e_wr && bus.done_psum && avail.size() < 2;
    e_valid = avail.size() > 0;
    if (model_ok) begin
      chk("busy", 32'(bus.busy), 32'(active));
      chk("wr_psum_in", 32'(bus.wr_psum_in), 32'(e_wr));
      chk("psum_ren", 32'(bus.psum_ren), 32'(e_ren));
      if (e_ren) begin
        chk("psum_raddr", 32'(bus.psum_raddr), 32'(issued));
        chk("co_psum", 32'(bus.co_psum), 32'(issued == len - 1));
      end else chk("co_psum_idle", 32'(bus.co_psum), 32'(0));
      chk("out_valid", 32'(bus.out_valid), 32'(e_valid));
      if (e_valid) begin
        chk("out_data", 32'(bus.out_data), 32'(avail[0].d));
        chk("out_last", 32'(bus.out_last), 32'(avail[0].last));
      end
    end
    s_pop = e_valid && bus.out_ready;
    s_ren = e_ren;
    s_drain = bus.drain_en;
    s_len = int'(bus.psum_len);
    s_rst = rst;
    if (bus.psum_ren) ren_log.push_back('{cyc: cyc, addr: int'(bus.psum_raddr), co: bus.co_psum});
    if (bus.out_valid && bus.out_ready)
      beat_log.push_back('{cyc: cyc, d: bus.out_data, last: bus.out_last});
    wr_hist[cyc] = bus.wr_psum_in;
    busy_hist[cyc] = bus.busy;
    cyc++;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while (bus.busy && k < budget) begin step(1); k++; end
    if (bus.busy) begin
      total++; bad++;
      $display("FAIL idle_timeout: got busy=1 want busy=0 within %0d cycles", budget);
    end
  endtask

  task automatic start_batch(input int l);
    ren_log.delete(); beat_log.delete();
    bus.psum_len = (AW + 1)'(l);
    bus.drain_en = 1'b1;
    step(1);
    bus.drain_en = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_wr"}, 32'(bus.wr_psum_in), 0);
    chk({tag, "_ren"}, 32'(bus.psum_ren), 0);
    chk({tag, "_co"}, 32'(bus.co_psum), 0);
    chk({tag, "_raddr"}, 32'(bus.psum_raddr), 0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 0);
    chk({tag, "_data"}, 32'(bus.out_data), 0);
    chk({tag, "_last"}, 32'(bus.out_last), 0);
  endtask

  initial begin
    int c;
    bus.drain_en = 0; bus.psum_len = '0; bus.done_psum = 0; bus.out_ready = 0;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    step(3);
    rst = 0;
    chk_reset_outputs("reset");

    // Basic drain
    mem[0] = 16'h11; mem[1] = 16'h22; mem[2] = 16'h33; mem[3] = 16'h44;
    bus.done_psum = 1; bus.out_ready = 1;
    start_batch(4);
    wait_idle(40); step(2);
    chk("basic_nreads", ren_log.size(), 4);
    chk("basic_nbeats", beat_log.size(), 4);
    if (ren_log.size() == 4 && beat_log.size() == 4) begin
      c = ren_log[0].cyc;
      for (int i = 0; i < 4; i++) begin
        chk("basic_addr", ren_log[i].addr, i);
        chk("basic_read_cyc", ren_log[i].cyc, c + i);
        chk("basic_co", 32'(ren_log[i].co), 32'(i == 3));
        chk("basic_beat_cyc", beat_log[i].cyc, c + 1 + i);
        chk("basic_last", 32'(beat_log[i].last), 32'(i == 3));
      end
      chk("basic_d0", 32'(beat_log[0].d), 32'h11);
      chk("basic_d1", 32'(beat_log[1].d), 32'h22);
      chk("basic_d2", 32'(beat_log[2].d), 32'h33);
      chk("basic_d3", 32'(beat_log[3].d), 32'h44);
      chk("basic_wr_after_co", 32'(wr_hist[c + 4]), 0);
      chk("basic_busy_flush", 32'(busy_hist[c + 4]), 1);
      chk("basic_busy_low", 32'(busy_hist[c + 5]), 0);
    end

    // Backpressure: out_ready low for cycles 3-10 of the batch
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    start_batch(8);
    step(2); bus.out_ready = 0;
    step(8); bus.out_ready = 1;
    wait_idle(60);
    chk("bp_nbeats", beat_log.size(), 8);
    for (int i = 0; i < beat_log.size() && i < 8; i++)
      chk("bp_data", 32'(beat_log[i].d), 32'(mem[i]));

    // done_psum gaps
    start_batch(5);
    for (int k = 0; k < 60 && bus.busy; k++) begin bus.done_psum = ~bus.done_psum; step(1); end
    wait_idle(20);
    bus.done_psum = 1;
    chk("gap_nreads", ren_log.size(), 5);
    for (int i = 0; i < ren_log.size() && i < 5; i++) begin
      chk("gap_addr", ren_log[i].addr, i);
      chk("gap_co", 32'(ren_log[i].co), 32'(i == 4));
    end

    // Length 1
    start_batch(1);
    wait_idle(20); step(1);
    chk("len1_nreads", ren_log.size(), 1);
    if (ren_log.size() == 1) begin
      chk("len1_co", 32'(ren_log[0].co), 1);
      chk("len1_wr_after", 32'(wr_hist[ren_log[0].cyc + 1]), 0);
    end

    // Length 0 is ignored
    ren_log.delete();
    bus.psum_len = '0; bus.drain_en = 1;
    for (int k = 0; k < 4; k++) begin
      step(1);
      chk("len0_busy", 32'(bus.busy), 0);
      chk("len0_wr", 32'(bus.wr_psum_in), 0);
    end
    bus.drain_en = 0;
    chk("len0_nreads", ren_log.size(), 0);

    // Length 20 clamps to DEPTH
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    start_batch(20);
    wait_idle(80);
    chk("len20_nreads", ren_log.size(), 16);
    for (int i = 0; i < ren_log.size() && i < 16; i++) chk("len20_addr", ren_log[i].addr, i);

    // Reset mid-batch with words buffered
    start_batch(8);
    for (int k = 0; k < 20 && ren_log.size() < 3; k++) step(1);
    if (ren_log.size() < 3) begin
      total++; bad++;
      $display("FAIL midrst_wait: got %0d reads want 3", ren_log.size());
    end
    bus.out_ready = 0; rst = 1;
    step(1);
    rst = 0;
    chk_reset_outputs("midrst");
    bus.out_ready = 1;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    start_batch(2);
    wait_idle(20);
    chk("midrst_nreads", ren_log.size(), 2);
    chk("midrst_nbeats", beat_log.size(), 2);
    for (int i = 0; i < ren_log.size() && i < 2; i++) chk("midrst_addr", ren_log[i].addr, i);
    for (int i = 0; i < beat_log.size() && i < 2; i++) begin
      chk("midrst_data", 32'(beat_log[i].d), 32'(mem[i]));
      chk("midrst_last", 32'(beat_log[i].last), 32'(i == 1));
    end

    // Back-to-back batches with drain_en held
    ren_log.delete(); beat_log.delete();
    bus.psum_len = 5'd3; bus.drain_en = 1;
    step(14);
    bus.drain_en = 0;
    wait_idle(20);
    chk("b2b_min_reads", 32'(ren_log.size() >= 6), 1);
    if (ren_log.size() >= 6) begin
      chk("b2b_restart_gap", ren_log[3].cyc - ren_log[2].cyc, 3);
      chk("b2b_wr_gap0", 32'(wr_hist[ren_log[2].cyc + 1]), 0);
      chk("b2b_wr_gap1", 32'(wr_hist[ren_log[2].cyc + 2]), 0);
      chk("b2b_addr_restart", ren_log[3].addr, 0);
    end

    // Randomized traffic
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
    for (int k = 0; k < 2000; k++) begin
      bus.done_psum = ($urandom_range(0, 9) < 7);
      bus.out_ready = ($urandom_range(0, 9) < 6);
      bus.drain_en  = ($urandom_range(0, 9) < 3);
      bus.psum_len  = (AW + 1)'($urandom_range(0, 20));
      rst = ($urandom_range(0, 199) == 0);
      step(1);
    end
    rst = 0; bus.drain_en = 0; bus.done_psum = 1; bus.out_ready = 1;
    wait_idle(100);
    step(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
